// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider (DIV) for the multicycle MIPS core.
// One quotient bit per clock, followed by a sign-fixup cycle and a one-cycle done pulse.
// Optional build macro DIVIDER_UNSIGNED_EN adds op_unsigned_i (DIVU): operands are
// taken as raw unsigned magnitudes and no sign correction is applied.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
`ifdef DIVIDER_UNSIGNED_EN
  input  logic             op_unsigned_i,
`endif
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] q_q, q_d;       // committed quotient
  logic [WIDTH-1:0] r_q, r_d;       // committed remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d; // negate quotient in SIGN
  logic             negr_q, negr_d; // negate remainder in SIGN
  logic             dz_q, dz_d;

  logic             uns;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_unused;

`ifdef DIVIDER_UNSIGNED_EN
  assign uns = op_unsigned_i;
`else
  assign uns = 1'b0;
`endif

  // Operand magnitudes; INT_MIN maps to 2^(WIDTH-1) as an unsigned magnitude.
  assign sgn_a = dividend_i[WIDTH-1] & ~uns;
  assign sgn_b = divisor_i[WIDTH-1] & ~uns;
  assign mag_a = sgn_a ? -dividend_i : dividend_i;
  assign mag_b = sgn_b ? -divisor_i : divisor_i;

  // Restoring step: the shifted remainder can exceed WIDTH bits, so the trial
  // subtraction carries an extra bit plus a sign bit.
  assign shifted      = {rem_q, quo_q[WIDTH-1]};
  assign trial        = {1'b0, shifted} - {2'b00, dvs_q};
  assign trial_unused = trial[WIDTH];

  // Next-state and datapath update for every register.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
            cnt_d   = CW'(WIDTH - 1);
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = SIGN;
      end
      SIGN: begin
        q_d     = negq_q ? -quo_q : quo_q;
        r_d     = negr_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      q_q    <= q_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
    end
  end

  assign busy_o      = (state_q == CALC) || (state_q == SIGN);
  assign done_o      = (state_q == DONE);
  assign div_zero_o  = dz_q;
  assign quotient_o  = q_q;
  assign remainder_o = r_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor
// pops and compares on every done pulse (values, div_zero, latency, busy length).
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op_uns;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
`ifdef DIVIDER_UNSIGNED_EN
    .op_unsigned_i(op_uns),
`endif
    .dividend_i(dividend), .divisor_i(divisor),
    .busy_o(busy), .done_o(done), .div_zero_o(div_zero),
    .quotient_o(quotient), .remainder_o(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q, r;
    logic         dz;
    int           cyc;
    int           bsy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: busy run length and scoreboard comparison on each done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (busy) busy_run++;
    else if (!done) busy_run = 0;
    if (done === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_zero", div_zero, e.dz);
        check("done_cycle", cyc, e.cyc);
        check("busy_cycles", busy_run, e.bsy);
      end
      busy_run = 0;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                       input bit exp_en, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int hold);
    exp_t e;
    @(negedge clk);
    dividend = a; divisor = b; op_uns = uns; start = 1'b1;
    if (exp_en) begin
      e.q = eq; e.r = er; e.dz = edz;
      e.cyc = cyc + (edz ? 1 : 34);
      e.bsy = edz ? 0 : 33;
      sbq.push_back(e);
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 60 && !(sbq.size() == 0 && busy === 1'b0 && done === 1'b0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check("timeout", 0, 1);
      sbq.delete();
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er);
    issue(a, b, 1'b0, 1, eq, er, 1'b0, 1);
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_uns = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);

    op(32'd100, 32'd7, 32'd14, 32'd2);
    op(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    op(32'd0, 32'd5, 32'd0, 32'd0);
    op(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    // Divide by zero after q=14,r=2; start held into the DONE cycle must be ignored.
    op(32'd100, 32'd7, 32'd14, 32'd2);
    issue(32'd5, 32'd0, 1'b0, 1, 32'd14, 32'd2, 1'b1, 2);
    wait_idle();
    op(32'd9, 32'd3, 32'd3, 32'd0);

    // Start pulse with new operands during CALC is ignored.
    issue(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2, 1'b0, 1);
    repeat (9) @(negedge clk);
    dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset during CALC: everything clears, no done pulse follows.
    issue(32'd1000, 32'd3, 1'b0, 0, '0, '0, 1'b0, 1);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_zero", div_zero, 0);
    repeat (40) @(negedge clk);
    op(32'd100, 32'd7, 32'd14, 32'd2);

`ifdef DIVIDER_UNSIGNED_EN
    issue(32'hFFFF_FFFF, 32'd2, 1'b1, 1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'd2, 1'b0, 1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    wait_idle();
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
